// File: rtl/axis_uart_cfg_master.sv
// AXI-Stream initiator for the UART dynamic-configuration channel.
// On a validated apply it sends a soft-reset word held for RESET_HOLD cycles,
// waits GAP_CYCLES idle cycles, and then offers the config word until the core
// accepts it or TIMEOUT_CYCLES stalled cycles pass.
module axis_uart_cfg_master #(
  parameter int RESET_HOLD     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MIN_PRESCALER  = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        apply,
  input  logic [15:0] cfg_prescaler,
  input  logic [2:0]  cfg_parity,
  input  logic [3:0]  cfg_byte_size,
  input  logic        cfg_stop_bits,
  input  logic        cfg_rx_en,
  input  logic        cfg_tx_en,
  output logic [26:0] m_axis_config_tdata,
  output logic        m_axis_config_tvalid,
  input  logic        m_axis_config_tready,
  output logic        busy,
  output logic        done,
  output logic        err_invalid,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_GAP,
    S_CFG,
    S_DONE
  } state_t;

  // Terminal counts; the GAP value is unused when GAP_CYCLES is 0 because
  // RST then hands over straight to CFG.
  localparam logic [7:0]  HOLD_LAST = 8'(RESET_HOLD - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] MIN_PS    = 16'(MIN_PRESCALER);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [25:0] shadow_q, shadow_d;
  logic        rst_bit_q, rst_bit_d;
  logic        err_invalid_q, err_invalid_d;
  logic        err_timeout_q, err_timeout_d;

  logic [25:0] cfg_word;
  logic        cfg_bad;

  assign cfg_word = {cfg_tx_en, cfg_rx_en, cfg_stop_bits, cfg_byte_size,
                     cfg_parity, cfg_prescaler};
  assign cfg_bad  = (cfg_parity > 3'd4) || (cfg_prescaler < MIN_PS);

  // The word is always built from the shadow; bit 26 tracks which phase we are in
  // and stays set through GAP so the data bus does not move between words.
  assign m_axis_config_tdata  = {rst_bit_q, shadow_q};
  assign m_axis_config_tvalid = (state_q == S_RST) || (state_q == S_CFG);
  assign busy                 = (state_q == S_RST) || (state_q == S_GAP) ||
                                (state_q == S_CFG);
  assign done                 = (state_q == S_DONE);
  assign err_invalid          = err_invalid_q;
  assign err_timeout          = err_timeout_q;

  // Next-state, counter and flag logic for the reset/gap/config sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    shadow_d      = shadow_q;
    rst_bit_d     = rst_bit_q;
    err_invalid_d = err_invalid_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (apply) begin
          shadow_d = cfg_word;
          if (cfg_bad) begin
            err_invalid_d = 1'b1;
          end else begin
            err_invalid_d = 1'b0;
            err_timeout_d = 1'b0;
            rst_bit_d     = 1'b1;
            cnt_d         = 8'd0;
            state_d       = S_RST;
          end
        end
      end

      S_RST: begin
        // tready is deliberately ignored: the core resets itself from
        // tvalid & tdata[26] without handshaking.
        if (cnt_q == HOLD_LAST) begin
          cnt_d = 8'd0;
          if (GAP_CYCLES == 0) begin
            rst_bit_d = 1'b0;
            tmo_d     = 16'd0;
            state_d   = S_CFG;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d     = 8'd0;
          rst_bit_d = 1'b0;
          tmo_d     = 16'd0;
          state_d   = S_CFG;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_CFG: begin
        // A transfer wins over a timeout landing on the same cycle.
        if (m_axis_config_tready) begin
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_q == TMO_LAST) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      tmo_q         <= 16'd0;
      shadow_q      <= 26'd0;
      rst_bit_q     <= 1'b0;
      err_invalid_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      shadow_q      <= shadow_d;
      rst_bit_q     <= rst_bit_d;
      err_invalid_q <= err_invalid_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule
